// File: rtl/sm_addsub_pipe.sv
// Two-stage adder/subtractor: A is two's complement, B is sign-magnitude.
// Stage 1 registers the converted operands; stage 2 holds the result and drives the outputs.
module sm_addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             Clk_in,
    input  logic             Rst_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic [1:0]       Sel_in,
    input  logic             Valid_in,
    output logic             Ready_out,
    output logic [WIDTH:0]   Rez_out,
    output logic             Ovf_out,
    output logic             Valid_out,
    input  logic             Ready_in
);

    typedef enum logic [1:0] {
        OP_ADD      = 2'b00,
        OP_SUB      = 2'b01,
        OP_ACC_ADD  = 2'b10,
        OP_ACC_LOAD = 2'b11
    } op_e;

    localparam int RW = WIDTH + 1;
    localparam int IW = WIDTH + 3;
    localparam logic signed [IW-1:0] SAT_MAX = {3'b000, {WIDTH{1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = {3'b111, {WIDTH{1'b0}}};

    logic                 s1Valid_q, s1Valid_d;
    logic                 s2Valid_q, s2Valid_d;
    logic [RW-1:0]        s1A_q, s1A_d;
    logic [RW-1:0]        s1B_q, s1B_d;
    op_e                  s1Op_q, s1Op_d;
    logic [RW-1:0]        rez_q, rez_d;
    logic [RW-1:0]        acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 s2Load;
    logic                 s1Move;
    logic                 isAcc;
    logic [RW-1:0]        bMag;
    logic signed [IW-1:0] aExt, bExt, accExt, sum;

    // Ready_out depends only on stage state and Ready_in, never on Valid_in.
    always_comb begin
        s2Load    = !s2Valid_q || Ready_in;
        s1Move    = s1Valid_q && s2Load;
        Ready_out = !s1Valid_q || s2Load;
    end

    always_comb begin
        bMag      = {2'b00, B_in[WIDTH-2:0]};
        s1Valid_d = s1Valid_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Op_d    = s1Op_q;
        if (Ready_out) begin
            s1Valid_d = Valid_in;
            if (Valid_in) begin
                s1A_d  = {A_in[WIDTH-1], A_in};
                // Negating a zero magnitude yields zero, so -0 needs no special case.
                s1B_d  = B_in[WIDTH-1] ? -bMag : bMag;
                s1Op_d = op_e'(Sel_in);
            end
        end
    end

    always_comb begin
        aExt   = {{2{s1A_q[RW-1]}}, s1A_q};
        bExt   = {{2{s1B_q[RW-1]}}, s1B_q};
        accExt = {{2{acc_q[RW-1]}}, acc_q};
        isAcc  = (s1Op_q == OP_ACC_ADD) || (s1Op_q == OP_ACC_LOAD);
        sum    = aExt + bExt;
        case (s1Op_q)
            OP_SUB:     sum = aExt - bExt;
            OP_ACC_ADD: sum = accExt + aExt + bExt;
            default:    sum = aExt + bExt;
        endcase

        rez_d = sum[RW-1:0];
        ovf_d = 1'b0;
        if (isAcc) begin
            if (SAT_EN) begin
                if (sum > SAT_MAX) begin
                    rez_d = SAT_MAX[RW-1:0];
                    ovf_d = 1'b1;
                end else if (sum < SAT_MIN) begin
                    rez_d = SAT_MIN[RW-1:0];
                    ovf_d = 1'b1;
                end
            end else begin
                ovf_d = ({{2{sum[RW-1]}}, sum[RW-1:0]} != sum);
            end
        end

        // The accumulator moves at S2 entry so a following ACC op already sees it.
        acc_d = acc_q;
        if (s1Move && isAcc) begin
            acc_d = rez_d;
        end

        s2Valid_d = s2Valid_q;
        if (s2Load) begin
            s2Valid_d = s1Valid_q;
        end
    end

    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Op_q    <= OP_ADD;
            rez_q     <= '0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s2Valid_q <= s2Valid_d;
            s1A_q     <= s1A_d;
            s1B_q     <= s1B_d;
            s1Op_q    <= s1Op_d;
            acc_q     <= acc_d;
            if (s1Move) begin
                rez_q <= rez_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign Rez_out   = rez_q;
    assign Ovf_out   = ovf_q;
    assign Valid_out = s2Valid_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Scoreboard bench for sm_addsub_pipe: a saturating and a wrapping instance share
// one stimulus stream, and an integer model predicts both results at issue time.
module tb_sm_addsub_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] aIn = '0;
    logic [W-1:0] bIn = '0;
    logic [1:0]   selIn = 2'b00;
    logic         validIn = 1'b0;
    logic         readyIn = 1'b1;

    logic         readyOutS, readyOutW;
    logic         validOutS, validOutW;
    logic         ovfS, ovfW;
    logic [W:0]   rezS, rezW;

    typedef struct {
        logic [W:0] rS;
        logic       oS;
        logic [W:0] rW;
        logic       oW;
    } exp_t;

    exp_t       sb[$];
    int         checkCount = 0;
    int         failCount = 0;
    int         outCount = 0;
    int         accS = 0;
    int         accW = 0;
    logic       prevHeld = 1'b0;
    logic [W:0] prevRez = '0;

    always #5 clk = ~clk;

    sm_addsub_pipe #(.WIDTH(W), .SAT_EN(1'b1)) dutSat (
        .Clk_in(clk), .Rst_in(rst), .A_in(aIn), .B_in(bIn), .Sel_in(selIn),
        .Valid_in(validIn), .Ready_out(readyOutS), .Rez_out(rezS), .Ovf_out(ovfS),
        .Valid_out(validOutS), .Ready_in(readyIn)
    );

    sm_addsub_pipe #(.WIDTH(W), .SAT_EN(1'b0)) dutWrap (
        .Clk_in(clk), .Rst_in(rst), .A_in(aIn), .B_in(bIn), .Sel_in(selIn),
        .Valid_in(validIn), .Ready_out(readyOutW), .Rez_out(rezW), .Ovf_out(ovfW),
        .Valid_out(validOutW), .Ready_in(readyIn)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int smVal(input logic [W-1:0] b);
        int m;
        m = int'(b[W-2:0]);
        return b[W-1] ? -m : m;
    endfunction

    function automatic int wrapVal(input int v);
        int m;
        m = v & ((1 << (W + 1)) - 1);
        if (m >= (1 << W)) m = m - (1 << (W + 1));
        return m;
    endfunction

    // Mid-cycle monitor: inputs and handshakes are stable here, so it predicts
    // accepted transactions and checks results that leave on the next edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   aV, bV, rS, rW;
        if (rst) begin
            sb.delete();
            accS = 0;
            accW = 0;
            prevHeld = 1'b0;
        end else begin
            checkOutput("valid_match", validOutW, validOutS);
            checkOutput("ready_match", readyOutW, readyOutS);
            if (prevHeld) begin
                checkOutput("hold_valid", validOutS, 1);
                checkOutput("hold_rez", rezS, prevRez);
            end
            prevHeld = validOutS && !readyIn;
            prevRez  = rezS;
            if (validOutS && readyIn) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    outCount++;
                    checkOutput("rez_sat", rezS, e.rS);
                    checkOutput("ovf_sat", ovfS, e.oS);
                    checkOutput("rez_wrap", rezW, e.rW);
                    checkOutput("ovf_wrap", ovfW, e.oW);
                end
            end
            if (validIn && readyOutS) begin
                aV = int'($signed(aIn));
                bV = smVal(bIn);
                case (selIn)
                    2'b01:   begin rS = aV - bV; rW = rS; end
                    2'b10:   begin rS = accS + aV + bV; rW = accW + aV + bV; end
                    default: begin rS = aV + bV; rW = rS; end
                endcase
                e.oS = 1'b0;
                e.oW = 1'b0;
                if (selIn[1]) begin
                    if (rS > (1 << W) - 1) begin
                        rS = (1 << W) - 1;
                        e.oS = 1'b1;
                    end else if (rS < -(1 << W)) begin
                        rS = -(1 << W);
                        e.oS = 1'b1;
                    end
                    accS = rS;
                    e.oW = (wrapVal(rW) != rW);
                    rW = wrapVal(rW);
                    accW = rW;
                end
                e.rS = rS[W:0];
                e.rW = rW[W:0];
                sb.push_back(e);
            end
        end
    end

    // Presents one transaction and holds it until the handshake edge has passed.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
        int n = 0;
        bit got = 1'b0;
        aIn = a;
        bIn = b;
        selIn = sel;
        validIn = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (readyOutS) got = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        validIn = 1'b0;
        readyIn = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_empty", sb.size(), 0);
        checkOutput("drain_idle", validOutS, 0);
    endtask

    // Four ADDs against a stalled consumer, then release and expect a gapless burst.
    task automatic backpressureTest();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        int k = 0;
        ta = '{8'h01, 8'h12, 8'hF0, 8'h85};
        tb = '{8'h02, 8'h83, 8'h10, 8'h7F};
        for (int cyc = 0; cyc < 10; cyc++) begin
            readyIn = (cyc >= 4);
            if (k < 4) begin
                aIn = ta[k];
                bIn = tb[k];
                selIn = 2'b00;
                validIn = 1'b1;
            end else begin
                validIn = 1'b0;
            end
            @(negedge clk);
            if (cyc == 2 || cyc == 3) checkOutput("bp_ready_low", readyOutS, 0);
            if (cyc == 3) checkOutput("bp_accepts", k, 2);
            if (cyc >= 4 && cyc <= 7) checkOutput("bp_stream", validOutS, 1);
            if (validIn && readyOutS) k++;
            @(posedge clk);
            #1;
        end
        checkOutput("bp_all_in", k, 4);
        drain();
    endtask

    task automatic randomTest();
        int k = 0;
        int n = 0;
        while (k < 24 && n < 400) begin
            readyIn = 1'($urandom_range(0, 1));
            aIn     = 8'($urandom);
            bIn     = 8'($urandom);
            selIn   = 2'($urandom);
            validIn = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (validIn && readyOutS) k++;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rand_accepts", k, 24);
        drain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", validOutS, 0);
        checkOutput("rst_rez", rezS, 0);
        checkOutput("rst_ovf", ovfS, 0);
        checkOutput("rst_rez_w", rezW, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", readyOutS, 1);
        @(posedge clk);
        #1;

        applyStimulus(8'h05, 8'h83, 2'b00);
        validIn = 1'b0;
        @(negedge clk);
        checkOutput("latency_c1", validOutS, 0);
        @(negedge clk);
        checkOutput("latency_c2", validOutS, 1);
        @(posedge clk);
        #1;
        drain();

        applyStimulus(8'h80, 8'h7F, 2'b01);
        applyStimulus(8'h7F, 8'hFF, 2'b01);
        applyStimulus(8'h00, 8'h80, 2'b00);
        drain();

        applyStimulus(8'h7F, 8'h00, 2'b11);
        applyStimulus(8'h7F, 8'h7F, 2'b10);
        applyStimulus(8'h80, 8'h00, 2'b10);
        drain();

        backpressureTest();
        randomTest();

        readyIn = 1'b0;
        applyStimulus(8'h10, 8'h00, 2'b11);
        applyStimulus(8'h20, 8'h05, 2'b10);
        validIn = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", validOutS, 0);
        checkOutput("midrst_rez", rezS, 0);
        checkOutput("midrst_ovf", ovfS, 0);
        checkOutput("midrst_valid_w", validOutW, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        readyIn = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h01, 8'h00, 2'b10);
        drain();

        checkOutput("sb_final_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
